segment_decoder: RTL and testbench

SEGMENT_DECODER -- requirements
Module: segment_decoder

---
 rtl/segment_decoder.sv | 168 ++++++++++++++++
 tb/tb_segment_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/segment_decoder.sv
// segment_decoder
//   Debounces and decodes an active-low seven-segment bus driven by an
//   external (asynchronous) display driver into a hex digit plus status.
//
//   Parameter
//     STABLE_CYCLES  synchronized cycles a pattern must stay unchanged
//                    before it is accepted (1..255)
//   Ports
//     clock          system clock, rising edge
//     reset          asynchronous active-high reset
//     seg_in[6:0]    active-low segments, bit0=a .. bit6=g
//     hex_out[3:0]   digit of the last accepted glyph
//     valid          last accepted pattern is a hex glyph
//     blank          last accepted pattern is all segments off
//     bad            last accepted pattern is neither glyph nor blank
//     change         one-cycle pulse when the accepted pattern differs
//                    from the previously accepted one
//     change_count   number of change pulses since reset (wraps)
//     err_count      (only with SEGMENT_DECODER_ERRCNT_EN defined)
//                    acceptances of bad patterns, saturating at 255
module segment_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg_in,
  output logic [3:0] hex_out,
  output logic       valid,
  output logic       blank,
  output logic       bad,
  output logic       change,
  output logic [7:0] change_count
`ifdef SEGMENT_DECODER_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } state_t;

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK_PAT  = 7'b1111111;

  state_t     state;
  state_t     next_state;
  logic [6:0] s1;
  logic [6:0] s;
  logic [7:0] cnt;
  logic [6:0] last_pat;
  logic       s_changed;
  logic       accept;
  logic       glyph_hit;
  logic [3:0] glyph_hex;

  // s1 holds the value s takes on the next edge, so comparing the two
  // tells us whether s is about to change on this edge.
  assign s_changed = (s1 != s);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= '1;
      s  <= '1;
    end else begin
      s1 <= seg_in;
      s  <= s1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (s_changed) begin
      cnt <= '0;
    end else if (cnt != STABLE_MAX) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A change of s on the would-be acceptance edge takes priority and
  // restarts the settle window.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    unique case (state)
      IDLE, SETTLE: begin
        if (s_changed) begin
          next_state = SETTLE;
        end else if (cnt == STABLE_MAX) begin
          accept     = 1'b1;
          next_state = LOCKED;
        end
      end
      LOCKED: begin
        if (s_changed) next_state = SETTLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    glyph_hit = 1'b1;
    glyph_hex = '0;
    unique case (s)
      7'b1000000: glyph_hex = 4'h0;
      7'b1111001: glyph_hex = 4'h1;
      7'b0100100: glyph_hex = 4'h2;
      7'b0110000: glyph_hex = 4'h3;
      7'b0011001: glyph_hex = 4'h4;
      7'b0010010: glyph_hex = 4'h5;
      7'b0000010: glyph_hex = 4'h6;
      7'b1111000: glyph_hex = 4'h7;
      7'b0000000: glyph_hex = 4'h8;
      7'b0011000: glyph_hex = 4'h9;
      7'b0001000: glyph_hex = 4'hA;
      7'b0000011: glyph_hex = 4'hB;
      7'b1000110: glyph_hex = 4'hC;
      7'b0100001: glyph_hex = 4'hD;
      7'b0000110: glyph_hex = 4'hE;
      7'b0001110: glyph_hex = 4'hF;
      default:    glyph_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hex_out      <= '0;
      valid        <= 1'b0;
      blank        <= 1'b1;
      bad          <= 1'b0;
      change       <= 1'b0;
      change_count <= '0;
      last_pat     <= BLANK_PAT;
    end else begin
      change <= 1'b0;
      if (accept) begin
        last_pat <= s;
        valid    <= glyph_hit;
        blank    <= (s == BLANK_PAT);
        bad      <= !glyph_hit && (s != BLANK_PAT);
        if (glyph_hit) hex_out <= glyph_hex;
        if (s != last_pat) begin
          change       <= 1'b1;
          change_count <= change_count + 8'd1;
        end
      end
    end
  end

`ifdef SEGMENT_DECODER_ERRCNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (accept && !glyph_hit && (s != BLANK_PAT) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_segment_decoder.sv
// tb_segment_decoder
//   Drives segment_decoder (STABLE_CYCLES=4) with directed scenarios and
//   randomized patterns; a reference model states the acceptance rule
//   directly: a pattern is accepted on the edge after it has been sampled
//   on STABLE_CYCLES+2 consecutive edges (reset counts as two blank
//   samples), once per run of identical samples.
module tb_segment_decoder;

  localparam int unsigned N = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] seg_in;
  logic [3:0] hex_out;
  logic       valid;
  logic       blank;
  logic       bad;
  logic       change;
  logic [7:0] change_count;
`ifdef SEGMENT_DECODER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  segment_decoder #(.STABLE_CYCLES(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .seg_in       (seg_in),
    .hex_out      (hex_out),
    .valid        (valid),
    .blank        (blank),
    .bad          (bad),
    .change       (change),
    .change_count (change_count)
`ifdef SEGMENT_DECODER_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clock = ~clock;

  localparam logic [6:0] GLYPHS [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  logic [6:0]  m_last_sample;
  int unsigned m_run;
  logic [6:0]  m_last_acc;
  logic [3:0]  m_hex;
  logic        m_valid, m_blank, m_bad, m_change;
  int unsigned m_count;
  int unsigned m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last_sample = 7'h7F;
    m_run         = 2;
    m_last_acc    = 7'h7F;
    m_hex         = '0;
    m_valid       = 1'b0;
    m_blank       = 1'b1;
    m_bad         = 1'b0;
    m_change      = 1'b0;
    m_count       = 0;
    m_err         = 0;
  endtask

  task automatic check_all();
    check("hex_out", 32'(hex_out), 32'(m_hex));
    check("valid", 32'(valid), 32'(m_valid));
    check("blank", 32'(blank), 32'(m_blank));
    check("bad", 32'(bad), 32'(m_bad));
    check("change", 32'(change), 32'(m_change));
    check("change_count", 32'(change_count), m_count);
`ifdef SEGMENT_DECODER_ERRCNT_EN
    check("err_count", 32'(err_count), m_err);
`endif
  endtask

  // One rising edge: decide acceptance from samples already seen, then
  // record this edge's sample, then compare outputs 1 time unit later.
  task automatic cycle();
    logic [6:0] p;
    int         idx;
    p = m_last_sample;
    @(posedge clock);
    m_change = 1'b0;
    if (m_run == N + 2) begin
      idx = -1;
      for (int unsigned g = 0; g < 16; g++)
        if (GLYPHS[g] == p) idx = int'(g);
      m_valid = (idx >= 0);
      m_blank = (p == 7'h7F);
      m_bad   = !m_valid && !m_blank;
      if (m_valid) m_hex = 4'(idx);
      if (m_bad && m_err < 255) m_err++;
      if (p != m_last_acc) begin
        m_change = 1'b1;
        m_count  = (m_count + 1) % 256;
      end
      m_last_acc = p;
    end
    if (seg_in == m_last_sample) begin
      if (m_run < N + 3) m_run++;
    end else begin
      m_last_sample = seg_in;
      m_run         = 1;
    end
    #1;
    check_all();
  endtask

  task automatic hold(input logic [6:0] pat, input int unsigned n);
    seg_in = pat;
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [6:0] pat;
    int unsigned sel;

    reset  = 1'b1;
    seg_in = 7'h7F;
    model_reset();
    #3;
    check_all();
    @(negedge clock);
    reset = 1'b0;

    // blank held after reset: blank stays, no change
    hold(7'b1111111, 10);
    check("s1_blank", 32'(blank), 32'd1);
    check("s1_count", 32'(change_count), 32'd0);

    // digit 3 accepted on the 7th edge
    hold(7'b0110000, 6);
    check("s2_not_yet", 32'(valid), 32'd0);
    hold(7'b0110000, 1);
    check("s2_hex", 32'(hex_out), 32'h3);
    check("s2_valid", 32'(valid), 32'd1);
    check("s2_change", 32'(change), 32'd1);
    check("s2_count", 32'(change_count), 32'd1);
    hold(7'b0110000, 1);
    check("s2_pulse_end", 32'(change), 32'd0);

    // 3-cycle glitch is ignored; re-acceptance of 3 gives no change
    hold(7'b0011001, 3);
    hold(7'b0110000, 12);
    check("s3_hex", 32'(hex_out), 32'h3);
    check("s3_count", 32'(change_count), 32'd1);

    // bad pattern
    hold(7'b0101010, 7);
    check("s4_bad", 32'(bad), 32'd1);
    check("s4_valid", 32'(valid), 32'd0);
    check("s4_hex", 32'(hex_out), 32'h3);
    check("s4_change", 32'(change), 32'd1);
`ifdef SEGMENT_DECODER_ERRCNT_EN
    check("s4_err", 32'(err_count), 32'd1);
`endif

    // alternate glyphs until change_count wraps back to 0
    for (int unsigned k = 0; k < 254; k++)
      hold((k % 2 == 0) ? GLYPHS[5] : GLYPHS[10], 7);
    check("s5_wrap", 32'(change_count), 32'd0);

    // reset mid-settle of digit 0
    hold(7'b1000000, 3);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b0;
    hold(7'b1000000, 6);
    check("s6_not_yet", 32'(valid), 32'd0);
    hold(7'b1000000, 1);
    check("s6_hex", 32'(hex_out), 32'h0);
    check("s6_valid", 32'(valid), 32'd1);

    // randomized patterns with random hold lengths
    for (int unsigned r = 0; r < 400; r++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       pat = GLYPHS[$urandom_range(0, 15)];
      else if (sel == 6) pat = 7'h7F;
      else               pat = 7'($urandom);
      hold(pat, $urandom_range(1, 9));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
